// File: rtl/lfsr_word_sequencer_if.sv
// Handshake and generator-control bundle between the LFSR word sequencer and its neighbours.
// master = sequencer side, slave = generator/downstream side.
interface lfsr_word_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int STEP_W = 8
);
    logic              start;
    logic [STEP_W-1:0] steps;
    logic              lfsr_enable;
    logic              lfsr_out_enable;
    logic              lfsr_out;
    logic              lfsr_valid;
    logic [DATA_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;
    logic              busy;
    logic              err;

    modport master (
        input  start, steps, lfsr_out, lfsr_valid, word_ready,
        output lfsr_enable, lfsr_out_enable, word_data, word_valid, busy, err
    );

    modport slave (
        output start, steps, lfsr_out, lfsr_valid, word_ready,
        input  lfsr_enable, lfsr_out_enable, word_data, word_valid, busy, err
    );
endinterface

// File: rtl/lfsr_word_sequencer.sv
// Steps an LFSR generator N times, unloads DATA_W serial bits LSB-first and offers the word.
// Latency: word_valid in cycle steps+DATA_W+2 after start; HOLD stalls until word_ready.
module lfsr_word_sequencer #(
    parameter int DATA_W = 8,
    parameter int STEP_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    lfsr_word_sequencer_if.master  bus
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STEP,
        ST_SHIFT,
        ST_DRAIN,
        ST_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              out_en_d_q, out_en_d_d;
    logic [DATA_W-1:0] capture_q, capture_d;
    logic [DATA_W-1:0] word_data_q, word_data_d;
    logic              err_q, err_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            step_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            out_en_d_q  <= 1'b0;
            capture_q   <= '0;
            word_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_cnt_q  <= step_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            out_en_d_q  <= out_en_d_d;
            capture_q   <= capture_d;
            word_data_q <= word_data_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        step_cnt_d  = step_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        capture_d   = capture_q;
        word_data_d = word_data_q;
        err_d       = err_q;
        out_en_d_d  = (state_q == ST_SHIFT);

        // The generator registers its serial bit, so sample one cycle after each unload enable.
        if (out_en_d_q) begin
            capture_d = {bus.lfsr_out, capture_q[DATA_W-1:1]};
            if (!bus.lfsr_valid) begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    step_cnt_d = bus.steps;
                    bit_cnt_d  = '0;
                    capture_d  = '0;
                    err_d      = 1'b0;
                    state_d    = (bus.steps != '0) ? ST_STEP : ST_SHIFT;
                end
            end
            ST_STEP: begin
                if (step_cnt_q != '0) begin
                    step_cnt_d = step_cnt_q - 1'b1;
                end
                if (step_cnt_q <= STEP_W'(1)) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
                    state_d   = ST_DRAIN;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                // capture_d already holds the final sample taken on this edge.
                word_data_d = capture_d;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.word_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.lfsr_enable     = (state_q == ST_STEP);
    assign bus.lfsr_out_enable = (state_q == ST_SHIFT);
    assign bus.word_valid      = (state_q == ST_HOLD);
    assign bus.busy            = (state_q != ST_IDLE);
    assign bus.word_data       = word_data_q;
    assign bus.err             = err_q;
endmodule
